// File: rtl/hazard_unit_if.sv
// Hazard unit bus: stage-tagged register addresses and control coming in from the
// datapath/controller, and stall/flush/forward controls going back out.
//   master : datapath/controller side (drives addresses/control, receives hazard controls)
//   slave  : hazard_unit side
// Parameter CNT_W sets the width of the performance counter outputs.
interface hazard_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    output PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    input  PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard manager for the 5-stage core: EX operand forwarding, load-use stall,
// branch/jump flush, and a data-memory wait-state FSM with timeout that freezes the pipe.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous, active-low reset
//   hz    : hazard_unit_if.slave (inputs Rs*/Rd*/ResultSrcE/PCSrcE/RegWrite*/MemReqM/MemReadyM,
//           outputs ForwardAE/BE, Stall*, Flush*, MemErr, StallCnt, FlushCnt)
// Optional feature: define HAZARD_PERF_EN to build the stall/flush performance counters;
// otherwise StallCnt/FlushCnt are constant 0 and no counter flops exist.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_unit_if.slave hz
);

  localparam int unsigned WaitCntW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_e;

  state_e              state_q;
  logic [WaitCntW-1:0] cnt_q;
  logic                mem_err_q;

  logic       mem_stall_c, lw_stall_c;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;

  // M stage has the younger result, so it wins over W; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic reg_wr_m,
                                         input logic [4:0] rd_m, input logic reg_wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (reg_wr_m && (rd_m != 5'd0) && (rd_m == rs))      sel = 2'b10;
    else if (reg_wr_w && (rd_w != 5'd0) && (rd_w == rs)) sel = 2'b01;
    return sel;
  endfunction

  // Memory stall: in RUN only an unanswered request stalls; in WAIT the access is
  // already outstanding so only MemReadyM matters; ERR freezes the pipe for good.
  always_comb begin
    mem_stall_c = 1'b0;
    unique case (state_q)
      ST_RUN:  mem_stall_c = hz.MemReqM && !hz.MemReadyM;
      ST_WAIT: mem_stall_c = !hz.MemReadyM;
      ST_ERR:  mem_stall_c = 1'b1;
      default: mem_stall_c = 1'b1;
    endcase
  end

  assign lw_stall_c = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Output priority: memory stall, then branch flush, then load-use stall.
  always_comb begin
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b1;
    flush_e = 1'b1;
    flush_w = 1'b1;
    if (reset) begin
      fwd_a = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      fwd_b = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      if (mem_stall_c) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b1;
      end else begin
        stall_f = lw_stall_c;
        stall_d = lw_stall_c;
        flush_d = hz.PCSrcE;
        flush_e = hz.PCSrcE | lw_stall_c;
        flush_w = 1'b0;
      end
    end
  end

  // Wait-state FSM; cnt stops at MEM_TIMEOUT when entering ERR, so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_stall_c) begin
            state_q <= ST_WAIT;
            cnt_q   <= WaitCntW'(1);
          end
        end
        ST_WAIT: begin
          if (hz.MemReadyM) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + WaitCntW'(1);
            if (cnt_q == WaitCntW'(MEM_TIMEOUT - 1)) begin
              state_q   <= ST_ERR;
              mem_err_q <= 1'b1;
            end
          end
        end
        ST_ERR:  mem_err_q <= 1'b1;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.MemErr    = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Flush outputs are forced high during reset, but the async clear keeps that out of the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f | stall_d | stall_e | stall_m) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_d | flush_e)                     flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.StallCnt = stall_cnt_q;
  assign hz.FlushCnt = flush_cnt_q;
`else
  assign hz.StallCnt = '0;
  assign hz.FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(CntW)) hz();

  hazard_unit #(.MEM_TIMEOUT(MemTimeout), .CNT_W(CntW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsrc;
    logic       pcsrc, regwm, regww, req, rdy;
  } stim_t;

  typedef struct {
    logic [1:0]      fa, fb;
    logic            sf, sd, se, sm, fd, fe, fw, err;
    logic [CntW-1:0] sc, fc;
    string           tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: consecutive memory-stall cycles, sticky error, event counts.
  int              stall_run;
  bit              m_err;
  logic [CntW-1:0] m_sc, m_fc;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
    if (s.regwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.regww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rs1d: 5'd0, rs2d: 5'd0, rs1e: 5'd0, rs2e: 5'd0, rde: 5'd0, rdm: 5'd0, rdw: 5'd0,
          rsrc: 2'd0, pcsrc: 1'b0, regwm: 1'b0, regww: 1'b0, req: 1'b0, rdy: 1'b0};
    return s;
  endfunction

  // One cycle of stimulus: drive just after the rising edge, predict, push expectation.
  task automatic apply(input stim_t s, input string tag, input bit rst_low);
    exp_t e;
    bit   mem, lw;
    @(posedge clk);
    #1;
    hz.Rs1D = s.rs1d; hz.Rs2D = s.rs2d; hz.Rs1E = s.rs1e; hz.Rs2E = s.rs2e;
    hz.RdE = s.rde; hz.RdM = s.rdm; hz.RdW = s.rdw; hz.ResultSrcE = s.rsrc;
    hz.PCSrcE = s.pcsrc; hz.RegWriteM = s.regwm; hz.RegWriteW = s.regww;
    hz.MemReqM = s.req; hz.MemReadyM = s.rdy;
    reset = !rst_low;
    e.tag = tag;
    if (rst_low) begin
      stall_run = 0; m_err = 0; m_sc = '0; m_fc = '0;
      e.fa = 2'b00; e.fb = 2'b00;
      e.sf = 0; e.sd = 0; e.se = 0; e.sm = 0;
      e.fd = 1; e.fe = 1; e.fw = 1; e.err = 0; e.sc = '0; e.fc = '0;
    end else begin
      mem = m_err || (stall_run > 0 ? !s.rdy : (s.req && !s.rdy));
      lw  = (s.rsrc == 2'b01) && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
      e.fa = ref_fwd(s.rs1e, s);
      e.fb = ref_fwd(s.rs2e, s);
      if (mem) begin
        e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fd = 0; e.fe = 0; e.fw = 1;
      end else begin
        e.sf = lw; e.sd = lw; e.se = 0; e.sm = 0; e.fd = s.pcsrc; e.fe = s.pcsrc | lw; e.fw = 0;
      end
      e.err = m_err;
      e.sc  = PerfEn ? m_sc : '0;
      e.fc  = PerfEn ? m_fc : '0;
      if (!m_err) begin
        if (mem) begin
          stall_run++;
          if (stall_run >= int'(MemTimeout)) m_err = 1;
        end else begin
          stall_run = 0;
        end
      end
      if (e.sf | e.sd | e.se | e.sm) m_sc = m_sc + 1;
      if (e.fd | e.fe)               m_fc = m_fc + 1;
    end
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%0h expected=%0h", tag, name, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.tag, "ForwardAE", 32'(hz.ForwardAE), 32'(e.fa));
        chk(e.tag, "ForwardBE", 32'(hz.ForwardBE), 32'(e.fb));
        chk(e.tag, "StallF", 32'(hz.StallF), 32'(e.sf));
        chk(e.tag, "StallD", 32'(hz.StallD), 32'(e.sd));
        chk(e.tag, "StallE", 32'(hz.StallE), 32'(e.se));
        chk(e.tag, "StallM", 32'(hz.StallM), 32'(e.sm));
        chk(e.tag, "FlushD", 32'(hz.FlushD), 32'(e.fd));
        chk(e.tag, "FlushE", 32'(hz.FlushE), 32'(e.fe));
        chk(e.tag, "FlushW", 32'(hz.FlushW), 32'(e.fw));
        chk(e.tag, "MemErr", 32'(hz.MemErr), 32'(e.err));
        chk(e.tag, "StallCnt", 32'(hz.StallCnt), 32'(e.sc));
        chk(e.tag, "FlushCnt", 32'(hz.FlushCnt), 32'(e.fc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    s = idle();
    apply(s, "reset", 1'b1);
    apply(s, "reset", 1'b1);
    apply(s, "idle", 1'b0);

    // Forwarding: M beats W, W used when only W matches, x0 never forwarded.
    s = idle(); s.regwm = 1; s.rdm = 5; s.rs1e = 5; s.regww = 1; s.rdw = 5; s.rs2e = 5;
    apply(s, "fwd_both", 1'b0);
    s = idle(); s.regwm = 1; s.rdm = 5; s.rs1e = 5; s.regww = 1; s.rdw = 6; s.rs2e = 6;
    apply(s, "fwd_mw", 1'b0);
    s = idle(); s.regwm = 1; s.rdm = 0; s.rs1e = 0; s.regww = 1; s.rdw = 0;
    apply(s, "fwd_x0", 1'b0);

    // Load-use stall for exactly one cycle, then none with RdE=0.
    s = idle(); s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7;
    apply(s, "lw_use", 1'b0);
    s = idle();
    apply(s, "lw_after", 1'b0);
    s = idle(); s.rsrc = 2'b01; s.rde = 0; s.rs2d = 0;
    apply(s, "lw_x0", 1'b0);

    // Branch flush, and branch together with load-use.
    s = idle(); s.pcsrc = 1;
    apply(s, "branch", 1'b0);
    s = idle(); s.pcsrc = 1; s.rsrc = 2'b01; s.rde = 3; s.rs1d = 3;
    apply(s, "br_lw", 1'b0);

    // Ready in the same cycle as the request: no stall, FSM stays in RUN.
    s = idle(); s.req = 1; s.rdy = 1;
    apply(s, "mem_fast", 1'b0);
    s = idle();
    apply(s, "mem_fast2", 1'b0);

    // Three wait cycles, then ready; a branch pending during the wait is deferred.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.req = 1; s.pcsrc = (i == 1); s.rsrc = 2'b01; s.rde = 2; s.rs1d = 2;
      apply(s, "mem_wait", 1'b0);
    end
    s = idle(); s.req = 1; s.rdy = 1;
    apply(s, "mem_done", 1'b0);
    s = idle();
    apply(s, "mem_resume", 1'b0);

    // Timeout into ERR: stalls persist with no request, MemErr sticks until reset.
    for (int i = 0; i < 7; i++) begin
      s = idle(); s.req = (i < 5); s.rdy = (i >= 5);
      apply(s, "mem_tmo", 1'b0);
    end
    s = idle();
    apply(s, "err_reset", 1'b1);
    apply(s, "err_clear", 1'b0);

    // Reset asserted while waiting on memory, then resume with no request.
    s = idle(); s.req = 1;
    apply(s, "wait_rst0", 1'b0);
    s = idle();
    apply(s, "wait_rst1", 1'b0);
    apply(s, "wait_rst", 1'b1);
    apply(s, "after_rst", 1'b0);

    // Counter scenario: two load-use stalls and one branch.
    apply(s, "perf_rst", 1'b1);
    s = idle(); s.rsrc = 2'b01; s.rde = 9; s.rs1d = 9;
    apply(s, "perf_lw", 1'b0);
    apply(s, "perf_lw", 1'b0);
    s = idle(); s.pcsrc = 1;
    apply(s, "perf_br", 1'b0);
    s = idle();
    apply(s, "perf_chk", 1'b0);

    // Randomized traffic with periodic reset to escape ERR.
    for (int i = 0; i < 400; i++) begin
      s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rde = 5'($urandom_range(0, 3)); s.rdm = 5'($urandom_range(0, 3));
      s.rdw = 5'($urandom_range(0, 3)); s.rsrc = 2'($urandom_range(0, 3));
      s.pcsrc = ($urandom_range(0, 3) == 0); s.regwm = 1'($urandom);
      s.regww = 1'($urandom); s.req = 1'($urandom);
      s.rdy = ($urandom_range(0, 3) != 0);
      apply(s, "rand", (i % 50) == 49);
    end

    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
